seq_div: RTL and testbench

// - Sequential unsigned divider: O = A / B by repeated subtraction, one subtract per clock.
// - Inverse of the ALU repeated-add multiply flow; sits beside ALU in the arithmetic datapath.
// - Start/done handshake; the result and flags hold until the next accepted start.

---
 rtl/seq_div_if.sv | 37 +++
 rtl/seq_div.sv | 135 +++++++++++++
 tb/tb_seq_div.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seq_div_if.sv
// Start/done handshake bundle for the sequential divider.
// SEQ_DIV_REM_EN adds the remainder signal R.
interface seq_div_if #(
  parameter int unsigned W = 8
);

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] O;
`ifdef SEQ_DIV_REM_EN
  logic [W-1:0] R;
`endif
  logic         busy;
  logic         done;
  logic         ERR;
  logic         ZERO;

  // Requester side: drives operands, observes result and flags.
  modport master (
    output start, A, B,
    input  O, busy, done, ERR, ZERO
`ifdef SEQ_DIV_REM_EN
    , input R
`endif
  );

  // Divider side.
  modport slave (
    input  start, A, B,
    output O, busy, done, ERR, ZERO
`ifdef SEQ_DIV_REM_EN
    , output R
`endif
  );

endinterface

// File: rtl/seq_div.sv
// Sequential unsigned divider: O = A / B by repeated subtraction, one
// subtract per clock. Result and flags hold until the next accepted start.
// Optional feature macro: SEQ_DIV_REM_EN (exposes the remainder on R).
module seq_div #(
  parameter int unsigned W = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_div_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] rem_q,   rem_d;
  logic [W-1:0] div_q,   div_d;
  logic [W-1:0] q_q,     q_d;
  logic [W-1:0] o_q,     o_d;
`ifdef SEQ_DIV_REM_EN
  logic [W-1:0] r_q,     r_d;
`endif
  logic         busy_q,  busy_d;
  logic         done_q,  done_d;
  logic         err_q,   err_d;
  logic         zero_q,  zero_d;

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    q_d     = q_q;
    o_d     = o_q;
`ifdef SEQ_DIV_REM_EN
    r_d     = r_q;
`endif
    err_d   = err_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d   = bus.A;
          div_d   = bus.B;
          q_d     = '0;
          err_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (div_q == '0) begin
          // Divide by zero: saturate quotient, remainder is the dividend.
          err_d   = 1'b1;
          o_d     = '1;
`ifdef SEQ_DIV_REM_EN
          r_d     = rem_q;
`endif
          zero_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (rem_q >= div_q) begin
          // Guarded subtract cannot underflow; q is bounded by 2^W-1.
          rem_d = rem_q - div_q;
          q_d   = q_q + W'(1);
        end else begin
          o_d     = q_q;
`ifdef SEQ_DIV_REM_EN
          r_d     = rem_q;
`endif
          zero_d  = (q_q == '0);
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      div_q   <= '0;
      q_q     <= '0;
      o_q     <= '0;
`ifdef SEQ_DIV_REM_EN
      r_q     <= '0;
`endif
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      q_q     <= q_d;
      o_q     <= o_d;
`ifdef SEQ_DIV_REM_EN
      r_q     <= r_d;
`endif
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  // Drive the interface straight from registers.
  assign bus.O    = o_q;
`ifdef SEQ_DIV_REM_EN
  assign bus.R    = r_q;
`endif
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ERR  = err_q;
  assign bus.ZERO = zero_q;

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: stimulus pushes expected results computed
// with plain arithmetic, a monitor pops and compares on every done pulse.
module tb_seq_div;

  localparam int unsigned W = 8;

  typedef struct {
    int o;
    int r;
    int err;
    int zero;
    int done_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;
  exp_t exp_q[$];

  seq_div_if #(.W(W)) bus ();

  seq_div #(.W(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used for latency checks.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: quotient/remainder from plain division, zero divisor saturates.
  function automatic exp_t model(input int a, input int b, input int acc_cyc);
    exp_t e;
    if (b == 0) begin
      e.o = (1 << W) - 1; e.r = a; e.err = 1; e.zero = 0;
      e.done_cyc = acc_cyc + 1;
    end else begin
      e.o = a / b; e.r = a % b; e.err = 0; e.zero = (a / b == 0) ? 1 : 0;
      e.done_cyc = acc_cyc + a / b + 1;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.done === 1'b1) begin
        if (prev_done) chk("done_one_cycle", 1, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("O", int'(bus.O), e.o);
`ifdef SEQ_DIV_REM_EN
          chk("R", int'(bus.R), e.r);
`endif
          chk("ERR", int'(bus.ERR), e.err);
          chk("ZERO", int'(bus.ZERO), e.zero);
          chk("latency", cyc, e.done_cyc);
        end
      end
      prev_done = bus.done;
    end
  end

  // Wait (at a falling edge) until the divider is idle, bounded.
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 600) begin
      @(negedge clk);
      n = n + 1;
    end
    if (n >= 600) chk("idle_timeout", 1, 0);
  endtask

  // Issue one operation; operands are scrambled right after acceptance.
  task automatic do_op(input int a, input int b, input bit push);
    wait_idle();
    bus.A     = W'(a);
    bus.B     = W'(b);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    if (push) exp_q.push_back(model(a, b, cyc));
    chk("busy_after_accept", int'(bus.busy), 1);
  endtask

  initial begin
    int a;
    int b;
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_O", int'(bus.O), 0);
`ifdef SEQ_DIV_REM_EN
    chk("rst_R", int'(bus.R), 0);
`endif
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ERR", int'(bus.ERR), 0);
    chk("rst_ZERO", int'(bus.ZERO), 0);
    rst = 1'b0;

    do_op(7, 2, 1);
    do_op(6, 0, 1);
    do_op(0, 5, 1);
    do_op(3, 9, 1);

    // Long operation with a start pulse that must be ignored.
    do_op(255, 1, 1);
    repeat (10) @(negedge clk);
    bus.A     = 8'd4;
    bus.B     = 8'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;

    // Reset in the middle of a run discards it.
    do_op(200, 3, 0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_O", int'(bus.O), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_ERR", int'(bus.ERR), 0);
    chk("midrst_ZERO", int'(bus.ZERO), 0);
    repeat (5) @(negedge clk);
    chk("midrst_busy_stays_low", int'(bus.busy), 0);

    do_op(9, 3, 1);

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      if (i < 4) b = int'($urandom_range(1, 3));
      do_op(a, b, 1);
    end

    wait_idle();
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
